// File: rtl/hex_dump_formatter_pkg.sv
// Shared constants for the hex dump formatter: ASCII control characters,
// FSM state encoding and the nibble-to-hex mapping.
package hex_dump_formatter_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_POP  = 3'd1;
    localparam logic [2:0] ST_HI   = 3'd2;
    localparam logic [2:0] ST_LO   = 3'd3;
    localparam logic [2:0] ST_SEP  = 3'd4;
    localparam logic [2:0] ST_CR   = 3'd5;
    localparam logic [2:0] ST_LF   = 3'd6;

    // Upper-case hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + 8'(nib);
        end
        return 8'h37 + 8'(nib);
    endfunction

endpackage

// File: rtl/hex_dump_formatter_bin2ascii.sv
// Converts one 4-bit nibble into its upper-case hex ASCII character.
//   nibble  in  4  binary value
//   ascii_c out 8  ASCII character (combinational)
module hex_dump_formatter_bin2ascii
    import hex_dump_formatter_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii_c
);

    assign ascii_c = nibble_to_hex(nibble);

endmodule

// File: rtl/hex_dump_formatter.sv
// Drains bytes from a first-word-fall-through rx FIFO and writes them to the
// uart tx FIFO as an upper-case hex dump: "HH " per byte, CR LF at every
// line wrap and at every frame end.
//   clk, reset          clock, asynchronous active-high reset
//   enable              allow consuming new bytes (sampled only in IDLE)
//   rx_empty/data/last  rx FIFO head (FWFT); rx_rd pops it
//   tx_full             uart tx FIFO full; wr_uart/w_data write a character
//   frames_dumped       count of frames fully printed (wraps)
//   busy                formatter is not idle
module hex_dump_formatter
    import hex_dump_formatter_pkg::*;
#(
    parameter int unsigned BYTES_PER_LINE = 16,
    parameter logic [7:0]  SEP_CHAR       = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    output logic        rx_rd,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic [15:0] frames_dumped,
    output logic        busy
);

    localparam int unsigned COL_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BYTES_PER_LINE - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [7:0]         byte_q, byte_d;
    logic               last_q, last_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [15:0]        frames_q, frames_d;
    logic [7:0]         hi_ascii, lo_ascii;

    // Hex digits of the latched byte
    hex_dump_formatter_bin2ascii u_hi (
        .nibble  (byte_q[7:4]),
        .ascii_c (hi_ascii)
    );

    hex_dump_formatter_bin2ascii u_lo (
        .nibble  (byte_q[3:0]),
        .ascii_c (lo_ascii)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            byte_q   <= 8'h00;
            last_q   <= 1'b0;
            col_q    <= '0;
            frames_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            last_q   <= last_d;
            col_q    <= col_d;
            frames_q <= frames_d;
        end
    end

    // Next state, pop strobe and write strobe; emit states only advance on an
    // accepted write so a full tx FIFO never drops a character
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        last_d   = last_q;
        col_d    = col_q;
        frames_d = frames_q;
        rx_rd    = 1'b0;
        wr_uart  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && !rx_empty) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                rx_rd   = 1'b1;
                byte_d  = rx_data;
                last_d  = rx_last;
                state_d = ST_HI;
            end
            ST_HI: begin
                wr_uart = !tx_full;
                if (!tx_full) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                wr_uart = !tx_full;
                if (!tx_full) begin
                    if (last_q) begin
                        // col is cleared at LF so a frame ending on a line edge gets one CR LF
                        state_d = ST_CR;
                    end else if (col_q == COL_LAST) begin
                        state_d = ST_CR;
                        col_d   = '0;
                    end else begin
                        state_d = ST_SEP;
                        col_d   = col_q + COL_W'(1);
                    end
                end
            end
            ST_SEP: begin
                wr_uart = !tx_full;
                if (!tx_full) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CR: begin
                wr_uart = !tx_full;
                if (!tx_full) begin
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                wr_uart = !tx_full;
                if (!tx_full) begin
                    state_d = ST_IDLE;
                    if (last_q) begin
                        col_d    = '0;
                        frames_d = frames_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Character mux: depends only on registered state and byte
    always_comb begin
        w_data = 8'h00;
        case (state_q)
            ST_HI:   w_data = hi_ascii;
            ST_LO:   w_data = lo_ascii;
            ST_SEP:  w_data = SEP_CHAR;
            ST_CR:   w_data = ASCII_CR;
            ST_LF:   w_data = ASCII_LF;
            default: w_data = 8'h00;
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign frames_dumped = frames_q;

endmodule

// File: tb/tb_hex_dump_formatter.sv
// Scoreboard bench for hex_dump_formatter: FIFO model feeds bytes, expected
// characters are queued as bytes are pushed and compared on every uart write.
module tb_hex_dump_formatter;

    localparam int unsigned BPL = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rx_empty;
    logic [7:0]  rx_data;
    logic        rx_last;
    logic        rx_rd;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [15:0] frames_dumped;
    logic        busy;

    hex_dump_formatter #(.BYTES_PER_LINE(BPL), .SEP_CHAR(8'h20)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rx_empty      (rx_empty),
        .rx_data       (rx_data),
        .rx_last       (rx_last),
        .rx_rd         (rx_rd),
        .tx_full       (tx_full),
        .wr_uart       (wr_uart),
        .w_data        (w_data),
        .frames_dumped (frames_dumped),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [8:0]  fifo_q[$];   // {last, data}
    logic [8:0]  exp_q[$];    // {frame_end, char}
    int          checks = 0;
    int          failures = 0;
    int          tb_col = 0;
    logic [15:0] exp_frames = 16'h0000;
    int          rd_count = 0;
    int          stall_cnt = 0;
    bit          stall_armed = 0;
    bit          reset_armed = 0;
    bit          rand_stall = 0;
    bit          prev_rd = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n <= 4'd9) return 8'd48 + {4'd0, n};
        return 8'd65 + {4'd0, n} - 8'd10;
    endfunction

    task automatic gen_byte(input logic [7:0] d, input logic last);
        exp_q.push_back({1'b0, hexc(d[7:4])});
        exp_q.push_back({1'b0, hexc(d[3:0])});
        if (last || tb_col == BPL - 1) begin
            exp_q.push_back({1'b0, 8'h0D});
            exp_q.push_back({last, 8'h0A});
            tb_col = 0;
        end else begin
            exp_q.push_back({1'b0, 8'h20});
            tb_col++;
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last);
        fifo_q.push_back({last, d});
        gen_byte(d, last);
    endtask

    task automatic drive_inputs();
        rx_empty = (fifo_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : fifo_q[0][7:0];
        rx_last  = rx_empty ? 1'b0  : fifo_q[0][8];
        tx_full  = (stall_cnt != 0) || (rand_stall && $urandom_range(0, 3) == 0);
        if (stall_cnt != 0) stall_cnt--;
    endtask

    task automatic do_reset_mid();
        logic [8:0] e;
        reset = 1'b1;
        #1;
        check("rst_rx_rd",   32'(rx_rd),         32'd0);
        check("rst_wr_uart", 32'(wr_uart),       32'd0);
        check("rst_w_data",  32'(w_data),        32'd0);
        check("rst_frames",  32'(frames_dumped), 32'd0);
        check("rst_busy",    32'(busy),          32'd0);
        reset_armed = 0;
        exp_frames  = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        tb_col = 0;
        foreach (fifo_q[i]) begin
            e = fifo_q[i];
            gen_byte(e[7:0], e[8]);
        end
        prev_rd = 0;
    endtask

    // One clock: drive at negedge, sample 1ns later, act on what the DUT will do at the posedge
    task automatic cycle();
        logic [8:0] e;
        @(negedge clk);
        drive_inputs();
        #1;
        if (prev_rd && !tx_full) check("pop_to_hi", 32'(wr_uart), 32'd1);
        if (tx_full) check("no_write_full", 32'(wr_uart), 32'd0);
        if (rx_rd) begin
            check("rd_nonempty", 32'(rx_empty), 32'd0);
            rd_count++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (wr_uart && reset_armed && w_data == 8'h20) begin
            do_reset_mid();
            return;
        end
        if (wr_uart) begin
            if (exp_q.size() == 0) begin
                check("spurious_char", 32'(w_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("char", 32'(w_data), 32'(e[7:0]));
                if (e[8]) exp_frames++;
            end
            if (stall_armed && w_data == 8'h42) begin
                stall_cnt   = 20;
                stall_armed = 0;
            end
        end
        prev_rd = rx_rd;
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cycle();
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy) done = 1;
        end
        check({tag, "_drain"}, 32'(done), 32'd1);
        check({tag, "_frames"}, 32'(frames_dumped), 32'(exp_frames));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        bit seen;
        reset = 1'b1; enable = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
        rx_last = 1'b0; tx_full = 1'b0;
        #2;
        check("reset_rx_rd",   32'(rx_rd),         32'd0);
        check("reset_wr_uart", 32'(wr_uart),       32'd0);
        check("reset_w_data",  32'(w_data),        32'd0);
        check("reset_frames",  32'(frames_dumped), 32'd0);
        check("reset_busy",    32'(busy),          32'd0);
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;

        // Three-byte frame
        rd0 = rd_count;
        push_byte(8'hA5, 0); push_byte(8'h0F, 0); push_byte(8'h3C, 1);
        drain("t1");
        check("t1_pops", 32'(rd_count - rd0), 32'd3);

        // 18-byte frame wraps after 16
        for (int i = 0; i < 18; i++) push_byte(8'(i), i == 17);
        drain("t2");

        // Exact 16-byte line then a short frame starting at column 0
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), i == 15);
        push_byte(8'hE9, 0); push_byte(8'h01, 1);
        drain("t3");

        // 20-cycle stall during the low nibble of B7
        stall_armed = 1;
        push_byte(8'h12, 0); push_byte(8'hB7, 0); push_byte(8'h34, 1);
        drain("t4");
        check("t4_stall_hit", 32'(stall_armed), 32'd0);

        // Enable low with data waiting: nothing consumed
        enable = 1'b0;
        rd0 = rd_count;
        push_byte(8'h5A, 0); push_byte(8'hC3, 1);
        for (int i = 0; i < 10; i++) cycle();
        check("t5_no_pop",  32'(rd_count - rd0), 32'd0);
        check("t5_idle",    32'(busy), 32'd0);
        // Enable, then drop it right after the pop: the byte completes, then halt
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            if (rx_rd) seen = 1;
        end
        check("t5_pop_seen", 32'(seen), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        check("t5_halt_busy", 32'(busy), 32'd0);
        check("t5_fifo_left", 32'(fifo_q.size()), 32'd1);
        check("t5_exp_left",  32'(exp_q.size()), 32'd4);
        enable = 1'b1;
        drain("t5");

        // Reset during SEP of a multi-byte frame
        reset_armed = 1;
        push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0); push_byte(8'h44, 1);
        drain("t6");
        check("t6_reset_hit", 32'(reset_armed), 32'd0);

        // Random backpressure over a few random frames
        rand_stall = 1;
        for (int f = 0; f < 3; f++) begin
            int n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) push_byte(8'($urandom_range(0, 255)), i == n - 1);
        end
        drain("t_rand");
        rand_stall = 0;

        // frames_dumped wraps from FFFF to 0
        @(negedge clk);
        force dut.frames_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames_q;
        exp_frames = 16'hFFFF;
        push_byte(8'h7E, 1);
        drain("t7");
        check("t7_wrap", 32'(frames_dumped), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
